mem_access: RTL and testbench

- Memory stage of the pipelined RV32I CPU.
- Sits directly downstream of the execute stage and upstream of writeback.
- Registers the ALU result, store data and control signals produced by execute, and performs byte/half/word loads and stores over a ready-handshaked data-memory port.
- Stalls the pipeline for multi-cycle accesses, then presents aligned, sign/zero-extended load data and forwarded control to writeback.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/load_align.sv | 44 ++++
 rtl/mem_access.sv | 167 ++++++++++++++++
 tb/tb_mem_access.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared funct3 access-size encodings and memory-stage FSM states
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // Natural alignment: bytes anywhere, halves on even, words on multiples of 4.
  function automatic logic f_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~a[0];
      default: return (a == 2'b00);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// load_align : selects the addressed byte/half of a read word and extends it
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// mem_access : RV32I memory stage - byte/half/word loads and stores over a
//              ready-handshaked data port, with stall, timeout and sticky err
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_access
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       rs2_value,
  input  logic [2:0]        funct3,
  input  logic              in_MemWrite,
  input  logic              in_MemRead,
  input  logic              in_RegWrite,
  input  logic [4:0]        in_RegDest,
  input  logic              in_MemToReg,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              out_RegWrite,
  output logic [4:0]        out_RegDest,
  output logic              out_MemToReg,
  output logic [31:0]       out_alu_result,
  output logic [31:0]       out_load_data,
  output logic              err
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [0:0]         r_state, w_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [31:0]        r_alu, r_rs2;
  logic [2:0]         r_f3;
  logic               r_mw, r_mr, r_rw, r_m2r, r_err;
  logic [4:0]         r_rd;

  logic               w_acc, w_timeout, w_start, w_misalign, w_in_mem;
  logic [3:0]         w_strb;
  logic [31:0]        w_load;

  assign w_acc      = (r_state == ST_ACCESS);
  assign w_timeout  = w_acc & ~mem_ready & (r_cnt == c_CNT_LAST);
  assign w_in_mem   = in_MemRead | in_MemWrite;
  assign w_start    = w_in_mem & f_aligned(funct3, alu_result[1:0]);
  assign w_misalign = w_in_mem & ~f_aligned(funct3, alu_result[1:0]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state: IDLE decides on the op being captured this edge
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_next = w_start ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_next = (mem_ready | w_timeout) ? ST_IDLE : ST_ACCESS;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Memory port outputs; a write request takes precedence over a read
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wstrb = 4'b0000;
    stall     = 1'b0;
    if (w_acc) begin
      mem_write = r_mw;
      mem_read  = r_mr & ~r_mw;
      mem_wstrb = r_mw ? w_strb : 4'b0000;
      stall     = ~(mem_ready | w_timeout);
    end
  end

  always_comb begin
    case (r_f3[1:0])
      2'b00: begin
        w_strb    = 4'b0001 << r_alu[1:0];
        mem_wdata = {4{r_rs2[7:0]}};
      end
      2'b01: begin
        w_strb    = 4'b0011 << r_alu[1:0];
        mem_wdata = {2{r_rs2[15:0]}};
      end
      default: begin
        w_strb    = 4'b1111;
        mem_wdata = r_rs2;
      end
    endcase
  end

  assign mem_addr = {r_alu[ADDR_W-1:2], 2'b00};

  load_align u_load_align (
    .i_rdata   (mem_rdata),
    .i_addr_lo (r_alu[1:0]),
    .i_funct3  (r_f3),
    .o_data    (w_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu <= '0;  r_rs2 <= '0;  r_f3 <= '0;  r_mw <= 1'b0;  r_mr <= 1'b0;
      r_rw  <= 1'b0; r_rd <= '0;  r_m2r <= 1'b0;
    end else if (!stall) begin
      r_alu <= alu_result;  r_rs2 <= rs2_value;  r_f3 <= funct3;
      r_mw  <= in_MemWrite; r_mr  <= in_MemRead; r_rw <= in_RegWrite;
      r_rd  <= in_RegDest;  r_m2r <= in_MemToReg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !w_acc) r_cnt <= '0;
    else               r_cnt <= r_cnt + 1'b1;
  end

  // Results: non-memory ops pass straight through; memory ops on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      out_RegWrite   <= 1'b0;
      out_RegDest    <= '0;
      out_MemToReg   <= 1'b0;
      out_alu_result <= '0;
      out_load_data  <= '0;
      r_err          <= 1'b0;
    end else if (!w_acc) begin
      if (w_in_mem) begin
        out_RegWrite <= 1'b0;
        if (w_misalign) r_err <= 1'b1;
      end else begin
        out_RegWrite   <= in_RegWrite;
        out_RegDest    <= in_RegDest;
        out_MemToReg   <= in_MemToReg;
        out_alu_result <= alu_result;
      end
    end else if (mem_ready) begin
      out_RegWrite   <= r_rw;
      out_RegDest    <= r_rd;
      out_MemToReg   <= r_m2r;
      out_alu_result <= r_alu;
      out_load_data  <= w_load;
    end else begin
      out_RegWrite <= 1'b0;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// tb_mem_access : randomized self-checking bench for mem_access
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

  localparam int TIMEOUT = 16;
  localparam int ADDR_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       alu_result, rs2_value, mem_rdata;
  logic [2:0]        funct3;
  logic              in_MemWrite, in_MemRead, in_RegWrite, in_MemToReg, mem_ready;
  logic [4:0]        in_RegDest;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, out_alu_result, out_load_data;
  logic [3:0]        mem_wstrb;
  logic              mem_read, mem_write, stall, out_RegWrite, out_MemToReg, err;
  logic [4:0]        out_RegDest;

  int n_checks = 0;
  int n_errors = 0;
  bit m_err    = 1'b0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .rs2_value(rs2_value),
    .funct3(funct3), .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead),
    .in_RegWrite(in_RegWrite), .in_RegDest(in_RegDest), .in_MemToReg(in_MemToReg),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .stall(stall), .out_RegWrite(out_RegWrite),
    .out_RegDest(out_RegDest), .out_MemToReg(out_MemToReg),
    .out_alu_result(out_alu_result), .out_load_data(out_load_data), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes, lane strobes/data, extended load
  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
    int nb = nbytes(f3);
    if (nb == 4) return 4'hF;
    return 4'(((1 << nb) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] r;
    int nb = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = rs2[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int    nb = nbytes(f3);
    longint v = longint'(rdata) >> (8 * (addr % 4));
    if (nb < 4) begin
      v = v % (64'sd1 << (8 * nb));
      if (!f3[2] && v >= (64'sd1 << (8 * nb - 1))) v = v - (64'sd1 << (8 * nb));
    end
    return 32'(v);
  endfunction

  task automatic drive_nop();
    alu_result = '0; rs2_value = '0; funct3 = '0; in_MemWrite = 0; in_MemRead = 0;
    in_RegWrite = 0; in_RegDest = '0; in_MemToReg = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive_nop(); mem_ready = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    m_err = 1'b0;
    check("rst_regwrite", {31'd0, out_RegWrite}, 0);
    check("rst_alu", out_alu_result, 0);
    check("rst_load", out_load_data, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_read", {31'd0, mem_read}, 0);
    rst = 1'b0;
  endtask

  // Issue one op from an idle stage; dly = ACCESS cycle in which ready rises
  task automatic run_op(input bit rd_en, input bit wr_en, input bit rw, input bit m2r,
                        input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [2:0] f3,
                        input logic [31:0] rdata, input int dly);
    bit mem   = rd_en | wr_en;
    bit ok    = (addr % nbytes(f3)) == 0;
    bit store = wr_en;
    bit got   = 1'b0;
    alu_result = addr; rs2_value = rs2; funct3 = f3; in_MemRead = rd_en;
    in_MemWrite = wr_en; in_RegWrite = rw; in_RegDest = rd; in_MemToReg = m2r;
    #1 check("idle_stall", {31'd0, stall}, 0);
    @(negedge clk);
    drive_nop();
    if (!mem) begin
      check("alu_regwrite", {31'd0, out_RegWrite}, {31'd0, rw});
      check("alu_rd", {27'd0, out_RegDest}, {27'd0, rd});
      check("alu_result", out_alu_result, addr);
      check("alu_m2r", {31'd0, out_MemToReg}, {31'd0, m2r});
      check("alu_stall", {31'd0, stall}, 0);
      check("alu_read", {31'd0, mem_read}, 0);
    end else if (!ok) begin
      m_err = 1'b1;
      check("mis_read", {31'd0, mem_read}, 0);
      check("mis_write", {31'd0, mem_write}, 0);
      check("mis_stall", {31'd0, stall}, 0);
      check("mis_regwrite", {31'd0, out_RegWrite}, 0);
    end else begin
      for (int k = 0; k < TIMEOUT; k++) begin
        mem_rdata = rdata;
        mem_ready = (k == dly);
        #1;
        check("acc_addr", mem_addr, {addr[31:2], 2'b00});
        check("acc_write", {31'd0, mem_write}, {31'd0, store});
        check("acc_read", {31'd0, mem_read}, {31'd0, !store});
        check("acc_strb", {28'd0, mem_wstrb}, store ? {28'd0, exp_strb(f3, addr)} : 0);
        if (store) check("acc_wdata", mem_wdata, exp_wdata(f3, rs2));
        check("acc_stall", {31'd0, stall}, {31'd0, !(k == dly || k == TIMEOUT - 1)});
        check("acc_bubble", {31'd0, out_RegWrite}, 0);
        if (k == dly) got = 1'b1;
        if (k == dly || k == TIMEOUT - 1) break;
        @(negedge clk);
      end
      @(negedge clk);
      mem_ready = 0;
      if (got) begin
        check("done_regwrite", {31'd0, out_RegWrite}, {31'd0, rw});
        check("done_rd", {27'd0, out_RegDest}, {27'd0, rd});
        check("done_alu", out_alu_result, addr);
        check("done_m2r", {31'd0, out_MemToReg}, {31'd0, m2r});
        if (!store) check("done_load", out_load_data, exp_load(f3, addr, rdata));
      end else begin
        m_err = 1'b1;
        check("tmo_regwrite", {31'd0, out_RegWrite}, 0);
      end
      check("done_stall", {31'd0, stall}, 0);
      check("done_read", {31'd0, mem_read}, 0);
      check("done_write", {31'd0, mem_write}, 0);
    end
    check("err", {31'd0, err}, {31'd0, m_err});
  endtask

  initial begin
    logic [2:0] f3s [5];
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
    do_reset();

    run_op(0, 0, 1, 0, 5'd5, 32'h1234, 32'h0, 3'b010, 32'h0, 0);
    run_op(0, 1, 0, 0, 5'd0, 32'h103, 32'hAABBCCDD, 3'b000, 32'h0, 3);
    run_op(1, 0, 1, 1, 5'd7, 32'h102, 32'h0, 3'b000, 32'h00800000, 0);
    run_op(1, 0, 1, 1, 5'd7, 32'h102, 32'h0, 3'b100, 32'h00800000, 0);
    run_op(1, 1, 0, 0, 5'd3, 32'h206, 32'h12345678, 3'b001, 32'h0, 1);
    run_op(1, 0, 1, 1, 5'd9, 32'h102, 32'h0, 3'b010, 32'h0, 0);
    run_op(1, 0, 1, 1, 5'd9, 32'h400, 32'h0, 3'b010, 32'hCAFEF00D, 999);

    // Reset in the middle of an access
    alu_result = 32'h200; funct3 = 3'b010; in_MemRead = 1; in_RegWrite = 1;
    @(negedge clk);
    drive_nop(); mem_ready = 0;
    @(negedge clk);
    check("pre_rst_read", {31'd0, mem_read}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_read", {31'd0, mem_read}, 0);
    check("mid_rst_stall", {31'd0, stall}, 0);
    check("mid_rst_err", {31'd0, err}, 0);
    check("mid_rst_regwrite", {31'd0, out_RegWrite}, 0);
    check("mid_rst_alu", out_alu_result, 0);
    check("mid_rst_strb", {28'd0, mem_wstrb}, 0);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      int kind = $urandom_range(0, 3);
      int dly  = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 4);
      logic [31:0] addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      if ($urandom_range(0, 24) == 0) do_reset();
      case (kind)
        0: run_op(0, 0, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
                  3'($urandom), 32'h0, 0);
        1: run_op(1, 0, 1'($urandom), 1'($urandom), 5'($urandom), addr, $urandom,
                  f3s[$urandom_range(0, 4)], $urandom, dly);
        2: run_op(0, 1, 1'($urandom), 1'($urandom), 5'($urandom), addr, $urandom,
                  f3s[$urandom_range(0, 2)], $urandom, dly);
        default: run_op(1, 1, 1'($urandom), 1'($urandom), 5'($urandom), addr, $urandom,
                        f3s[$urandom_range(0, 2)], $urandom, dly);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
